// File: rtl/sprite_pkg.sv
// Shared constants, FSM state encoding and the issue-order helper for the sprite fetch scheduler.
package sprite_pkg;

    localparam int N_REQ        = 3;
    localparam int REQ_BALL     = 0;
    localparam int REQ_LSCORE   = 1;
    localparam int REQ_RSCORE   = 2;
    localparam int SPRITE_DIM   = 50;
    localparam int SPRITE_WORDS = 2500;
    localparam int SPRITE_COUNT = 37;
    localparam int BALL_GLYPH   = 36;
    localparam int ADDR_W       = 18;
    localparam int ID_W         = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetchState_e;

    // First set bit of mask, searching upward from start and wrapping at N_REQ.
    function automatic logic [ID_W-1:0] pickNext(input logic [N_REQ-1:0] mask,
                                                 input logic [ID_W-1:0]  start);
        logic            found;
        int              idx;
        logic [ID_W-1:0] sel;
        found = 1'b0;
        sel   = start;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(start) + off) % N_REQ;
            if (!found && mask[idx]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sprite_fetch_tag_pipe.sv
// DEPTH-deep shift register of {valid, id} that follows each ROM read until its data returns.
module sprite_fetch_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            flush,
    input  logic            pushVld,
    input  logic [ID_W-1:0] pushId,
    output logic            outVld,
    output logic [ID_W-1:0] outId,
    output logic            busy
);

    logic [DEPTH-1:0] vld;
    logic [ID_W-1:0]  ids [DEPTH];

    // Flush empties the older stages but still accepts this cycle's push.
    always_ff @(posedge clk) begin
        vld[0] <= pushVld;
        ids[0] <= pushId;
        for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= flush ? 1'b0 : vld[i-1];
            ids[i] <= ids[i-1];
        end
    end

    assign outVld = vld[DEPTH-1];
    assign outId  = ids[DEPTH-1];

    // busy: reads still in flight beyond the one returning this cycle.
    if (DEPTH > 1) begin : g_inner
        assign busy = |vld[DEPTH-2:0];
    end else begin : g_none
        assign busy = 1'b0;
    end

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Shares the 1-bit sprite ROM between ball/left/right score requesters, one pixel of latency.
// SPRITE_FETCH_RR_EN: rotate the starting requester on every pixel instead of fixed 0,1,2 order.
module sprite_fetch_scheduler
    import sprite_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_stb,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic                    rom_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic                    rom_data,
    output logic [N_REQ-1:0]        sprite_bit,
    output logic                    sprite_vld,
    output logic                    overrun,
    output logic [1:0]              fsmState
);

    fetchState_e             state;
    logic [N_REQ-1:0]        pending;
    logic [N_REQ*ADDR_W-1:0] addrLatch;
    logic [ID_W-1:0]         startIdx;
    logic [ID_W-1:0]         rrIdx;
    logic [N_REQ-1:0]        cap;

    logic [N_REQ-1:0]        srcMask;
    logic [N_REQ-1:0]        remMask;
    logic [N_REQ-1:0]        capNext;
    logic [ID_W-1:0]         srcStart;
    logic [ID_W-1:0]         issueId;
    logic [N_REQ*ADDR_W-1:0] srcAddrs;
    logic                    issueAny;
    logic                    outVld;
    logic [ID_W-1:0]         outId;
    logic                    pipeBusy;

`ifdef SPRITE_FETCH_RR_EN
    always_ff @(posedge clk) begin
        if (reset)
            rrIdx <= '0;
        else if (pix_stb)
            rrIdx <= (rrIdx == ID_W'(N_REQ - 1)) ? '0 : rrIdx + 1'b1;
    end
`else
    assign rrIdx = '0;
`endif

    // No backpressure anywhere: rom_en is a read strobe the ROM must accept, and
    // sprite_vld is a one-cycle strobe the consumer must take when it is high.
    always_comb begin
        srcMask  = pix_stb ? req : pending;
        srcStart = pix_stb ? rrIdx : startIdx;
        srcAddrs = pix_stb ? req_addr : addrLatch;
        issueAny = (srcMask != '0);
        issueId  = pickNext(srcMask, srcStart);
        remMask  = srcMask & ~(N_REQ'(1) << issueId);
        capNext  = cap;
        if (outVld)
            capNext[outId] = rom_data;
    end

    sprite_fetch_tag_pipe #(
        .DEPTH (ROM_LAT),
        .ID_W  (ID_W)
    ) u_tagPipe (
        .clk     (clk),
        .flush   (reset || pix_stb),
        .pushVld (issueAny && !reset),
        .pushId  (issueId),
        .outVld  (outVld),
        .outId   (outId),
        .busy    (pipeBusy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            addrLatch  <= '0;
            startIdx   <= '0;
            cap        <= '0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            sprite_bit <= '0;
            sprite_vld <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sprite_vld <= pix_stb;
            rom_en     <= issueAny;
            if (issueAny)
                rom_addr <= srcAddrs[int'(issueId)*ADDR_W +: ADDR_W];

            if (pix_stb) begin
                // A return landing on the boundary is already folded into capNext.
                sprite_bit <= capNext;
                cap        <= '0;
                if (pending != '0 || pipeBusy)
                    overrun <= 1'b1;
                addrLatch <= req_addr;
                startIdx  <= rrIdx;
                pending   <= remMask;
                if (req == '0)
                    state <= IDLE;
                else if (remMask != '0)
                    state <= ISSUE;
                else
                    state <= DRAIN;
            end else begin
                cap <= capNext;
                case (state)
                    ISSUE: begin
                        pending <= remMask;
                        if (remMask == '0)
                            state <= DRAIN;
                    end
                    DRAIN: begin
                        if (!pipeBusy)
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fsmState = state;

endmodule
